decode_unit: RTL and testbench

Instruction decode stage for the single-clock LEGv8 pipeline. It latches each fetched instruction into the IF/ID register and drives `read_register1`/`read_register2` to the register file. It generates the control bundle, sign-extended immediate and destination register into the ID/EX register. It also detects load-use hazards, inserting one bubble and stalling fetch, and honours branch flushes from downstream.

---
 rtl/decode_unit.sv | 98 +++++++++
 tb/tb_decode_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_unit.sv
// decode_unit: LEGv8 ID stage with IF/ID and ID/EX registers, load-use stall and flush
module decode_unit #(
   parameter int WORD = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   input  logic [31:0]     instruction,
   input  logic [WORD-1:0] pc_in,
   input  logic            flush,
   output logic [4:0]      read_register1,
   output logic [4:0]      read_register2,
   output logic            stall,
   output logic            valid_out,
   output logic [WORD-1:0] pc_out,
   output logic [4:0]      write_register,
   output logic [WORD-1:0] sign_extended_imm,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic            mem_to_reg,
   output logic            alu_src,
   output logic            uncond_branch,
   output logic            branch,
   output logic [1:0]      alu_op,
   output logic            illegal_op
);
   logic            ifid_valid;
   logic [31:0]     ir;
   logic [WORD-1:0] ifid_pc;
   logic [10:0]     op;
   logic            is_r, is_ld, is_st, is_cbz, is_b, legal, reg2loc, hazard, bubble;
   logic [WORD-1:0] imm;
   always_comb begin
      op = ir[31:21];
      is_r = op == 11'b10001011000 || op == 11'b11001011000 || op == 11'b10001010000 || op == 11'b10101010000;
      is_ld = op == 11'b11111000010;
      is_st = op == 11'b11111000000;
      is_cbz = ir[31:24] == 8'b10110100;
      is_b = ir[31:26] == 6'b000101;
      legal = is_r || is_ld || is_st || is_cbz || is_b;
      reg2loc = is_ld || is_st || is_cbz;
      imm = (is_ld || is_st) ? {{(WORD-9){ir[20]}}, ir[20:12]} :
            is_cbz ? {{(WORD-19){ir[23]}}, ir[23:5]} :
            is_b ? {{(WORD-26){ir[25]}}, ir[25:0]} : '0;
      read_register1 = ir[9:5];
      read_register2 = reg2loc ? ir[4:0] : ir[20:16];
      // a load's own Rt sits in the rr2 field but is not a source operand
      hazard = valid_out && mem_read && ifid_valid && write_register != 5'd31 &&
               (write_register == read_register1 || ((is_r || is_st || is_cbz) && write_register == read_register2));
      stall = hazard && !flush;
      bubble = flush || hazard || !ifid_valid;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         ifid_valid <= 1'b0;
         ir <= '0;
         ifid_pc <= '0;
      end else if (flush) begin
         ifid_valid <= 1'b0;
      end else if (!stall) begin
         ifid_valid <= instr_valid;
         ir <= instruction;
         ifid_pc <= pc_in;
      end
   end
   always_ff @(posedge clk) begin
      if (reset || bubble) begin
         valid_out <= 1'b0;
         illegal_op <= 1'b0;
         pc_out <= '0;
         write_register <= '0;
         sign_extended_imm <= '0;
         reg_write <= 1'b0;
         mem_read <= 1'b0;
         mem_write <= 1'b0;
         mem_to_reg <= 1'b0;
         alu_src <= 1'b0;
         uncond_branch <= 1'b0;
         branch <= 1'b0;
         alu_op <= 2'b00;
      end else begin
         valid_out <= legal;
         illegal_op <= !legal;
         pc_out <= ifid_pc;
         write_register <= ir[4:0];
         sign_extended_imm <= imm;
         reg_write <= (is_r || is_ld) && ir[4:0] != 5'd31;
         mem_read <= is_ld;
         mem_write <= is_st;
         mem_to_reg <= is_ld;
         alu_src <= is_ld || is_st;
         uncond_branch <= is_b;
         branch <= is_cbz;
         alu_op <= is_r ? 2'b10 : is_cbz ? 2'b01 : 2'b00;
      end
   end
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: vector table, hazard/flush/reset sequences and a randomized reference model
module tb_decode_unit;
   logic        clk = 0, reset, instr_valid, flush;
   logic [31:0] instruction;
   logic [63:0] pc_in, pc_out, sign_extended_imm;
   logic [4:0]  read_register1, read_register2, write_register;
   logic        stall, valid_out, reg_write, mem_read, mem_write, mem_to_reg, alu_src, uncond_branch, branch, illegal_op;
   logic [1:0]  alu_op;
   logic [10:0] ctrl;
   int          checks = 0, passes = 0;

   decode_unit #(.WORD(64)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instruction(instruction), .pc_in(pc_in),
      .flush(flush), .read_register1(read_register1), .read_register2(read_register2), .stall(stall),
      .valid_out(valid_out), .pc_out(pc_out), .write_register(write_register),
      .sign_extended_imm(sign_extended_imm), .reg_write(reg_write), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src), .uncond_branch(uncond_branch),
      .branch(branch), .alu_op(alu_op), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;
   // {valid, illegal, reg_write, mem_read, mem_write, mem_to_reg, alu_src, uncond_branch, branch, alu_op}
   assign ctrl = {valid_out, illegal_op, reg_write, mem_read, mem_write, mem_to_reg, alu_src, uncond_branch, branch, alu_op};

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rr1, rr2, wr;
      logic [63:0] imm;
      logic [10:0] ctrl;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc, imm;
      logic [4:0]  rr1, rr2, wr;
      logic [10:0] ctrl;
      logic        use2;
   } dec_t;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s: got %0h expected %0h", n, a, e);
   endtask

   function automatic logic [4:0] rg();
      int v = $urandom_range(0, 4);
      return v == 4 ? 5'd31 : 5'(v);
   endfunction

   // builds an instruction from chosen fields and records what decode must produce
   function automatic dec_t gen(input int k);
      dec_t d;
      logic [4:0] a = rg(), b = rg(), t = rg();
      logic [8:0] i9 = 9'($urandom);
      logic [18:0] i19 = 19'($urandom);
      logic [25:0] i26 = 26'($urandom);
      logic [10:0] ops[4] = '{11'h458, 11'h658, 11'h450, 11'h550};
      d = '{default: '0};
      d.pc = 64'h4000 + 64'(k) * 4;
      case ($urandom_range(0, 6))
         0, 1: begin
            d.instr = {ops[$urandom_range(0, 3)], b, 6'($urandom), a, t};
            d.rr2 = b; d.use2 = 1; d.ctrl = {2'b10, t != 5'd31, 6'b0, 2'b10};
         end
         2: begin
            d.instr = {11'h7C2, i9, 2'b00, a, t};
            d.rr2 = t; d.imm = {{55{i9[8]}}, i9}; d.ctrl = {2'b10, t != 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
         end
         3: begin
            d.instr = {11'h7C0, i9, 2'b00, a, t};
            d.rr2 = t; d.use2 = 1; d.imm = {{55{i9[8]}}, i9}; d.ctrl = {2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00};
         end
         4: begin
            d.instr = {8'hB4, i19, t};
            d.rr2 = t; d.use2 = 1; d.imm = {{45{i19[18]}}, i19}; d.ctrl = {2'b10, 6'b0, 1'b1, 2'b01};
         end
         5: begin
            d.instr = {6'b000101, i26};
            d.rr2 = i26[20:16]; d.imm = {{38{i26[25]}}, i26}; d.ctrl = {2'b10, 5'b0, 1'b1, 1'b0, 2'b00};
         end
         default: begin
            d.instr = {8'hFF, 24'($urandom)};
            d.rr2 = d.instr[20:16]; d.ctrl = {2'b01, 9'b0};
         end
      endcase
      d.rr1 = d.instr[9:5];
      d.wr = d.instr[4:0];
      return d;
   endfunction

   task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic exp_st, input string n);
      @(negedge clk); instruction = a; instr_valid = 1;
      @(negedge clk); instruction = b;
      @(negedge clk); #1;
      chk({n, "_stall"}, stall, exp_st);
      chk({n, "_rr1"}, read_register1, b[9:5]);
      if (exp_st) begin
         @(negedge clk); #1;
         chk({n, "_stall_once"}, stall, 0);
         chk({n, "_bubble"}, valid_out, 0);
      end
      instr_valid = 0;
      @(posedge clk); #1;
      chk({n, "_valid"}, valid_out, 1);
      chk({n, "_wr"}, write_register, b[4:0]);
   endtask

   task automatic idle_reset();
      @(negedge clk); reset = 1; instr_valid = 0; flush = 0;
      @(posedge clk);
      @(negedge clk); reset = 0;
   endtask

   vec_t tbl[13];
   dec_t cur, ifid_m, idex_m;
   logic ifid_v, st_m, in_v, fl, bub;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{32'h8B020023, 5'd1,  5'd2,  5'd3,  64'd0, 11'b10100000010};
      tbl[1]  = '{32'hF85F8025, 5'd1,  5'd5,  5'd5,  64'hFFFFFFFFFFFFFFF8, 11'b10110110000};
      tbl[2]  = '{32'hF8010047, 5'd2,  5'd7,  5'd7,  64'd16, 11'b10001010000};
      tbl[3]  = '{32'hB4FFFFC4, 5'd30, 5'd4,  5'd4,  64'hFFFFFFFFFFFFFFFE, 11'b10000000101};
      tbl[4]  = '{32'h14000005, 5'd0,  5'd0,  5'd5,  64'd5, 11'b10000001000};
      tbl[5]  = '{32'h17FFFFFF, 5'd31, 5'd31, 5'd31, 64'hFFFFFFFFFFFFFFFF, 11'b10000001000};
      tbl[6]  = '{32'h8B02003F, 5'd1,  5'd2,  5'd31, 64'd0, 11'b10000000010};
      tbl[7]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd0,  64'd0, 11'b01000000000};
      tbl[8]  = '{32'hCB0B0149, 5'd10, 5'd11, 5'd9,  64'd0, 11'b10100000010};
      tbl[9]  = '{32'h8A030041, 5'd2,  5'd3,  5'd1,  64'd0, 11'b10100000010};
      tbl[10] = '{32'hAA1602B4, 5'd21, 5'd22, 5'd20, 64'd0, 11'b10100000010};
      tbl[11] = '{32'hF84003FF, 5'd31, 5'd31, 5'd31, 64'd0, 11'b10010110000};
      tbl[12] = '{32'h8B200000, 5'd0,  5'd0,  5'd0,  64'd0, 11'b01000000000};

      reset = 1; instr_valid = 0; flush = 0; instruction = '0; pc_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ctrl", ctrl, 0);
      chk("rst_pc", pc_out, 0);
      chk("rst_imm", sign_extended_imm, 0);
      chk("rst_wr", write_register, 0);
      chk("rst_stall", stall, 0);
      @(negedge clk); reset = 0;

      for (int i = 0; i < 13; i++) begin
         @(negedge clk); instruction = tbl[i].instr; pc_in = 64'h1000 + 64'(i) * 4; instr_valid = 1;
         @(negedge clk); instr_valid = 0; #1;
         chk($sformatf("v%0d_rr1", i), read_register1, tbl[i].rr1);
         chk($sformatf("v%0d_rr2", i), read_register2, tbl[i].rr2);
         @(posedge clk); #1;
         chk($sformatf("v%0d_ctrl", i), ctrl, tbl[i].ctrl);
         if (tbl[i].ctrl[10]) begin
            chk($sformatf("v%0d_wr", i), write_register, tbl[i].wr);
            chk($sformatf("v%0d_imm", i), sign_extended_imm, tbl[i].imm);
            chk($sformatf("v%0d_pc", i), pc_out, 64'h1000 + 64'(i) * 4);
         end
         @(posedge clk); #1;
         chk($sformatf("v%0d_after", i), ctrl, 0);
      end

      pair(32'hF8400025, 32'h8B0200A6, 1, "ld_add_rn");
      pair(32'hF8400025, 32'h8B050046, 1, "ld_add_rm");
      pair(32'hF8400025, 32'hF8000025, 1, "ld_stur");
      pair(32'hF8400025, 32'hB4000005, 1, "ld_cbz");
      pair(32'hF8400025, 32'hF8400045, 0, "ld_ld_rt");
      pair(32'hF840003F, 32'h8B0203E6, 0, "ld_xzr");
      pair(32'hF8000025, 32'h8B0200A6, 0, "st_add");
      pair(32'hF8400025, 32'h8B020026, 0, "ld_indep");

      @(negedge clk); instruction = 32'hF8400025; instr_valid = 1;
      @(negedge clk); instruction = 32'h8B0200A6;
      @(negedge clk); #1;
      chk("fl_pre_stall", stall, 1);
      flush = 1; #1;
      chk("fl_stall", stall, 0);
      @(negedge clk); flush = 0; instr_valid = 0; #1;
      chk("fl_bubble", valid_out, 0);
      chk("fl_stall_after", stall, 0);
      @(posedge clk); #1;
      chk("fl_killed", valid_out, 0);

      @(negedge clk); instruction = 32'hF8400025; instr_valid = 1;
      @(negedge clk); instruction = 32'h8B0200A6;
      @(negedge clk); #1;
      chk("rs_pre_stall", stall, 1);
      reset = 1;
      @(posedge clk); #1;
      chk("rs_ctrl", ctrl, 0);
      chk("rs_pc", pc_out, 0);
      chk("rs_stall", stall, 0);
      @(negedge clk); reset = 0; instr_valid = 0;
      @(posedge clk); #1;
      chk("rs_lost", valid_out, 0);

      idle_reset();
      ifid_m = '{default: '0}; idex_m = '{default: '0}; cur = '{default: '0};
      ifid_v = 0; st_m = 0; in_v = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (!st_m) begin
            cur = gen(c);
            in_v = $urandom_range(0, 4) != 0;
         end
         fl = $urandom_range(0, 9) == 0;
         instruction = cur.instr; pc_in = cur.pc; instr_valid = in_v; flush = fl;
         st_m = !fl && ifid_v && idex_m.ctrl[10] && idex_m.ctrl[7] && idex_m.wr != 5'd31 &&
                (idex_m.wr == ifid_m.rr1 || (ifid_m.use2 && idex_m.wr == ifid_m.rr2));
         bub = fl || st_m || !ifid_v;
         #1;
         chk("rnd_stall", stall, st_m);
         if (ifid_v) begin
            chk("rnd_rr1", read_register1, ifid_m.rr1);
            chk("rnd_rr2", read_register2, ifid_m.rr2);
         end
         @(posedge clk);
         idex_m = bub ? '{default: '0} : ifid_m;
         if (fl) ifid_v = 0;
         else if (!st_m) begin
            ifid_m = cur;
            ifid_v = in_v;
         end
         #1;
         chk("rnd_ctrl", ctrl, idex_m.ctrl);
         if (idex_m.ctrl[10]) begin
            chk("rnd_pc", pc_out, idex_m.pc);
            chk("rnd_wr", write_register, idex_m.wr);
            chk("rnd_imm", sign_extended_imm, idex_m.imm);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
